// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped, write-through cache controller.
// State codes are plain constants so older code that compares raw state values keeps working.
package cache_pkg;

   localparam int unsigned DEFAULT_INDEX_WIDTH  = 8;
   localparam int unsigned DEFAULT_OFFSET_WIDTH = 3;
   localparam int unsigned DEFAULT_TAG_WIDTH    =
      32 - 2 - DEFAULT_INDEX_WIDTH - DEFAULT_OFFSET_WIDTH;
   localparam int unsigned LINE_WORDS           = 1 << DEFAULT_OFFSET_WIDTH;

   localparam logic [2:0] StIdle      = 3'd0;
   localparam logic [2:0] StLookup    = 3'd1;
   localparam logic [2:0] StRefill    = 3'd2;
   localparam logic [2:0] StWriteThru = 3'd3;
   localparam logic [2:0] StFlush     = 3'd4;

   // CPU request captured in IDLE; the byte-lane bits of the address are not kept.
   typedef struct packed {
      logic        we;
      logic [29:0] waddr;
      logic [31:0] wdata;
   } cpu_req_t;

endpackage

// File: rtl/cache_line_ram.sv
// Tag and data arrays of the cache. Asynchronous read of one tag and one word; synchronous
// write of the tag and of one data word. Contents are never cleared.
module cache_line_ram #(
   parameter int unsigned INDEX_WIDTH  = 8,
   parameter int unsigned OFFSET_WIDTH = 3,
   parameter int unsigned TAG_WIDTH    = 19
) (
   input  logic                    clk,
   input  logic [INDEX_WIDTH-1:0]  index_i,
   input  logic [OFFSET_WIDTH-1:0] roffset_i,
   output logic [TAG_WIDTH-1:0]    tag_rdata_o,
   output logic [31:0]             data_rdata_o,
   input  logic                    tag_we_i,
   input  logic [TAG_WIDTH-1:0]    tag_wdata_i,
   input  logic                    data_we_i,
   input  logic [OFFSET_WIDTH-1:0] woffset_i,
   input  logic [31:0]             data_wdata_i
);

   localparam int unsigned Lines = 1 << INDEX_WIDTH;
   localparam int unsigned Words = 1 << (INDEX_WIDTH + OFFSET_WIDTH);

   logic [TAG_WIDTH-1:0] tag_mem [Lines];
   logic [31:0]          data_mem [Words];

   always_ff @(posedge clk) begin
      if (tag_we_i) begin
         tag_mem[index_i] <= tag_wdata_i;
      end
      if (data_we_i) begin
         data_mem[{index_i, woffset_i}] <= data_wdata_i;
      end
   end

   assign tag_rdata_o  = tag_mem[index_i];
   assign data_rdata_o = data_mem[{index_i, roffset_i}];

endmodule

// File: rtl/cache_vmem.sv
// Valid-bit memory: asynchronous read, one synchronous write port, and a synchronous
// reset that clears every entry at once.
module cache_vmem #(
   parameter int unsigned DATA_WIDTH = 1,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [(1 << ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] mem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cache_refill_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller: hit/miss decision,
// word-by-word line refill on load misses, store forwarding, and single-cycle flush.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned INDEX_WIDTH  = DEFAULT_INDEX_WIDTH,
   parameter int unsigned OFFSET_WIDTH = DEFAULT_OFFSET_WIDTH,
   parameter int unsigned TAG_WIDTH    = 32 - 2 - INDEX_WIDTH - OFFSET_WIDTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_wdata_i,
   output logic [31:0] cpu_rdata_o,
   output logic        cpu_ready_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   input  logic        flush_i,
   output logic        flush_busy_o
);

   logic [2:0]              state_q, state_d;
   logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
   cpu_req_t                req_q, req_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    ready_q, ready_d;

   logic [TAG_WIDTH-1:0]    req_tag;
   logic [INDEX_WIDTH-1:0]  req_index;
   logic [OFFSET_WIDTH-1:0] req_offset;

   logic [TAG_WIDTH-1:0]    tag_rdata;
   logic [31:0]             word_rdata;
   logic                    tag_we;
   logic                    data_we;
   logic [OFFSET_WIDTH-1:0] data_woffset;
   logic [31:0]             data_wdata;

   logic                    valid_rdata;
   logic                    valid_we;
   logic                    valid_wdata;
   logic                    valid_rst;
   logic                    lookup_hit;
   logic                    unused_addr_bits;

   assign unused_addr_bits = ^cpu_addr_i[1:0];

   assign req_tag    = req_q.waddr[29 -: TAG_WIDTH];
   assign req_index  = req_q.waddr[OFFSET_WIDTH +: INDEX_WIDTH];
   assign req_offset = req_q.waddr[OFFSET_WIDTH-1:0];
   assign lookup_hit = valid_rdata & (tag_rdata == req_tag);

   // Being in FLUSH for one cycle wipes every valid bit at the closing edge.
   assign valid_rst  = rst | (state_q == StFlush);

   cache_vmem #(
      .DATA_WIDTH (1),
      .ADDR_WIDTH (INDEX_WIDTH)
   ) u_vmem (
      .clk     (clk),
      .rst     (valid_rst),
      .we_i    (valid_we),
      .waddr_i (req_index),
      .wdata_i (valid_wdata),
      .raddr_i (req_index),
      .rdata_o (valid_rdata)
   );

   cache_line_ram #(
      .INDEX_WIDTH  (INDEX_WIDTH),
      .OFFSET_WIDTH (OFFSET_WIDTH),
      .TAG_WIDTH    (TAG_WIDTH)
   ) u_line_ram (
      .clk          (clk),
      .index_i      (req_index),
      .roffset_i    (req_offset),
      .tag_rdata_o  (tag_rdata),
      .data_rdata_o (word_rdata),
      .tag_we_i     (tag_we),
      .tag_wdata_i  (req_tag),
      .data_we_i    (data_we),
      .woffset_i    (data_woffset),
      .data_wdata_i (data_wdata)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      rdata_d      = rdata_q;
      ready_d      = 1'b0;
      tag_we       = 1'b0;
      data_we      = 1'b0;
      data_woffset = req_offset;
      data_wdata   = req_q.wdata;
      valid_we     = 1'b0;
      valid_wdata  = 1'b0;

      case (state_q)
         StIdle: begin
            if (flush_i) begin
               state_d = StFlush;
            end else if (cpu_req_i) begin
               req_d.we    = cpu_we_i;
               req_d.waddr = cpu_addr_i[31:2];
               req_d.wdata = cpu_wdata_i;
               state_d     = StLookup;
            end
         end
         StLookup: begin
            if (!req_q.we) begin
               if (lookup_hit) begin
                  rdata_d = word_rdata;
                  ready_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  // Drop the line before refilling so a reset mid-refill leaves it invalid.
                  valid_we = 1'b1;
                  cnt_d    = '0;
                  state_d  = StRefill;
               end
            end else begin
               data_we = lookup_hit;
               state_d = StWriteThru;
            end
         end
         StRefill: begin
            if (mem_ack_i) begin
               data_we      = 1'b1;
               data_woffset = cnt_q;
               data_wdata   = mem_rdata_i;
               cnt_d        = cnt_q + 1'b1;
               if (cnt_q == {OFFSET_WIDTH{1'b1}}) begin
                  tag_we      = 1'b1;
                  valid_we    = 1'b1;
                  valid_wdata = 1'b1;
                  state_d     = StLookup;
               end
            end
         end
         StWriteThru: begin
            if (mem_ack_i) begin
               ready_d = 1'b1;
               state_d = StIdle;
            end
         end
         StFlush: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (state_q == StRefill) begin
         mem_req_o  = 1'b1;
         mem_addr_o = {req_tag, req_index, cnt_q, 2'b00};
      end else if (state_q == StWriteThru) begin
         mem_req_o   = 1'b1;
         mem_we_o    = 1'b1;
         mem_addr_o  = {req_q.waddr, 2'b00};
         mem_wdata_o = req_q.wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         req_q   <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
      end
   end

   assign cpu_rdata_o  = rdata_q;
   assign cpu_ready_o  = ready_q;
   assign flush_busy_o = (state_q == StFlush);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: behavioural cache/memory model, one compare
// process on the falling edge, and directed scenarios with hand-computed expectations.
module tb_cache_refill_ctrl;
   import cache_pkg::*;

   localparam int unsigned IW = DEFAULT_INDEX_WIDTH;
   localparam int unsigned OW = DEFAULT_OFFSET_WIDTH;
   localparam int unsigned TW = DEFAULT_TAG_WIDTH;
   localparam int unsigned LW = LINE_WORDS;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req, cpu_we, cpu_ready, mem_req, mem_we, mem_ack, flush, flush_busy;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   cache_refill_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_req_i    (cpu_req),
      .cpu_we_i     (cpu_we),
      .cpu_addr_i   (cpu_addr),
      .cpu_wdata_i  (cpu_wdata),
      .cpu_rdata_o  (cpu_rdata),
      .cpu_ready_o  (cpu_ready),
      .mem_req_o    (mem_req),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata),
      .mem_ack_i    (mem_ack),
      .flush_i      (flush),
      .flush_busy_o (flush_busy)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   logic [31:0]   bmem [bit [31:0]];
   bit            mv [1 << IW];
   logic [TW-1:0] mt [1 << IW];
   logic [31:0]   md [1 << (IW + OW)];
   bus_t          exp_bus [$];
   logic [31:0]   obs_addr [$];
   logic [31:0]   exp_rdata;
   bit            exp_is_load;
   bit            op_pending;
   int            flush_cnt;
   int            ack_period;

   function automatic logic [31:0] memval(input logic [31:0] a);
      if (bmem.exists(a)) return bmem[a];
      return 32'h100 + ((a - 32'h40) >> 2);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_invalidate();
      for (int i = 0; i < (1 << IW); i++) mv[i] = 1'b0;
   endtask

   task automatic model_op(input bit we, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] exp_data, output int exp_lat);
      int            idx, off;
      logic [TW-1:0] tag;
      logic [31:0]   line, wa;
      bus_t          e;
      idx  = int'((a >> (2 + OW)) & ((1 << IW) - 1));
      off  = int'((a >> 2) & (LW - 1));
      tag  = a[31 -: TW];
      line = a & ~((LW * 4) - 1);
      wa   = a & 32'hFFFF_FFFC;
      exp_data = 32'h0;
      if (!we) begin
         if (mv[idx] && mt[idx] == tag) begin
            exp_lat = 2;
         end else begin
            for (int i = 0; i < LW; i++) begin
               e.we = 1'b0; e.addr = line + 4 * i; e.wdata = 32'h0;
               exp_bus.push_back(e);
               md[idx * LW + i] = memval(line + 4 * i);
            end
            mv[idx] = 1'b1;
            mt[idx] = tag;
            exp_lat = 3 + LW;
         end
         exp_data = md[idx * LW + off];
      end else begin
         if (mv[idx] && mt[idx] == tag) md[idx * LW + off] = d;
         e.we = 1'b1; e.addr = wa; e.wdata = d;
         exp_bus.push_back(e);
         bmem[wa] = d;
         exp_lat = 3;
      end
   endtask

   // ---------------- memory responder ----------------
   initial begin
      int w;
      w = 0;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (mem_req && !rst) begin
            if (w >= ack_period - 1) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_we ? 32'h0 : memval(mem_addr);
               w = 0;
            end else begin
               w++;
            end
         end else begin
            w = 0;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req) begin
            if (exp_bus.size() == 0) begin
               chk("unexpected_mem_req", 32'(mem_req), 32'd0);
            end else begin
               chk("mem_addr", mem_addr, exp_bus[0].addr);
               chk("mem_we", 32'(mem_we), 32'(exp_bus[0].we));
               if (exp_bus[0].we) chk("mem_wdata", mem_wdata, exp_bus[0].wdata);
               if (mem_ack) begin
                  obs_addr.push_back(mem_addr);
                  void'(exp_bus.pop_front());
               end
            end
         end
         if (cpu_ready) begin
            chk("ready_expected", 32'(op_pending), 32'd1);
            if (op_pending && exp_is_load) chk("cpu_rdata", cpu_rdata, exp_rdata);
            op_pending = 1'b0;
         end
         if (flush_busy) begin
            flush_cnt++;
            chk("flush_during_op", 32'(op_pending), 32'd0);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic outputs_zero(input string tag);
      chk({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
      chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
      chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_flush_busy"}, 32'(flush_busy), 32'd0);
   endtask

   // Starts and ends just after a rising edge; flush_at raises flush that many cycles in.
   task automatic run_op(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input int flush_at, output logic [31:0] dut_rdata, output int lat);
      logic [31:0] exp_data;
      int          exp_lat, n;
      model_op(we, a, d, exp_data, exp_lat);
      exp_rdata   = exp_data;
      exp_is_load = !we;
      obs_addr.delete();
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      op_pending = 1'b1;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      n = 0;
      lat = -1;
      dut_rdata = 32'hx;
      while (n < 200) begin
         @(negedge clk);
         if (cpu_ready) begin
            lat = n + 1;
            dut_rdata = cpu_rdata;
            break;
         end
         @(posedge clk);
         #1;
         n++;
         if (n == flush_at) flush = 1'b1;
      end
      chk("op_completed", 32'(lat > 0), 32'd1);
      if (ack_period == 1) chk("latency", 32'(lat), 32'(exp_lat));
      chk("bus_drained", 32'(exp_bus.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] got;
      int          lat, fc, n, el;
      logic [31:0] ed;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; flush = 1'b0;
      ack_period = 1;
      flush_cnt = 0;
      op_pending = 1'b0;
      model_invalidate();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      outputs_zero("reset");
      @(posedge clk);
      #1;

      // Cold load miss of line 0x40, then a hit in the same line.
      run_op(1'b0, 32'h40, 32'h0, -1, got, lat);
      chk("load40_rdata", got, 32'h100);
      chk("load40_latency", 32'(lat), 32'd11);
      chk("load40_nreads", 32'(obs_addr.size()), 32'd8);
      if (obs_addr.size() == 8) begin
         chk("load40_first_addr", obs_addr[0], 32'h40);
         chk("load40_last_addr", obs_addr[7], 32'h5C);
      end
      run_op(1'b0, 32'h44, 32'h0, -1, got, lat);
      chk("load44_rdata", got, 32'h101);
      chk("load44_latency", 32'(lat), 32'd2);
      chk("load44_no_bus", 32'(obs_addr.size()), 32'd0);

      // Store hit updates the cache and writes through.
      run_op(1'b1, 32'h48, 32'hDEAD_BEEF, -1, got, lat);
      chk("store48_latency", 32'(lat), 32'd3);
      chk("store48_nwrites", 32'(obs_addr.size()), 32'd1);
      run_op(1'b0, 32'h48, 32'h0, -1, got, lat);
      chk("load48_rdata", got, 32'hDEAD_BEEF);
      chk("load48_latency", 32'(lat), 32'd2);

      // Store miss: no allocate, so the next load refills from memory.
      run_op(1'b1, 32'h1000, 32'h1234_5678, -1, got, lat);
      chk("store1000_latency", 32'(lat), 32'd3);
      run_op(1'b0, 32'h1000, 32'h0, -1, got, lat);
      chk("load1000_rdata", got, 32'h1234_5678);
      chk("load1000_latency", 32'(lat), 32'd11);

      // One-cycle flush from IDLE.
      fc = flush_cnt;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_busy_on", 32'(flush_busy), 32'd1);
      @(negedge clk);
      chk("flush_busy_off", 32'(flush_busy), 32'd0);
      chk("flush_pulses", 32'(flush_cnt - fc), 32'd1);
      model_invalidate();
      @(posedge clk);
      #1;
      run_op(1'b0, 32'h40, 32'h0, -1, got, lat);
      chk("reload40_rdata", got, 32'h100);
      chk("reload40_latency", 32'(lat), 32'd11);
      run_op(1'b0, 32'h48, 32'h0, -1, got, lat);
      chk("reload48_rdata", got, 32'hDEAD_BEEF);

      // Reset after three refill acks.
      model_op(1'b0, 32'h5000, 32'h0, ed, el);
      exp_rdata = ed; exp_is_load = 1'b1;
      obs_addr.delete();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5000; cpu_wdata = 32'h0;
      op_pending = 1'b1;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      n = 0;
      while (obs_addr.size() < 3 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("pre_reset_acks", 32'(obs_addr.size()), 32'd3);
      #1;
      rst = 1'b1;
      exp_bus.delete();
      op_pending = 1'b0;
      model_invalidate();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      outputs_zero("midrst");
      @(posedge clk);
      #1;
      run_op(1'b0, 32'h5000, 32'h0, -1, got, lat);
      chk("load5000_rdata", got, 32'h14F0);
      chk("load5000_latency", 32'(lat), 32'd11);
      chk("load5000_nreads", 32'(obs_addr.size()), 32'd8);

      // Throttled memory with flush raised mid-refill; flush must wait for completion.
      ack_period = 3;
      fc = flush_cnt;
      run_op(1'b0, 32'h3000, 32'h0, 4, got, lat);
      chk("throttle_rdata", got, 32'hCF0);
      chk("throttle_lat_min", 32'(lat >= 25), 32'd1);
      @(negedge clk);
      chk("late_flush_busy_on", 32'(flush_busy), 32'd1);
      flush = 1'b0;
      @(negedge clk);
      chk("late_flush_busy_off", 32'(flush_busy), 32'd0);
      chk("late_flush_pulses", 32'(flush_cnt - fc), 32'd1);
      model_invalidate();
      ack_period = 1;
      @(posedge clk);
      #1;
      run_op(1'b0, 32'h3004, 32'h0, -1, got, lat);
      chk("post_flush_rdata", got, 32'hCF1);
      chk("post_flush_latency", 32'(lat), 32'd11);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Direct-mapped, write-through, no-write-allocate cache controller sitting between the CPU memory port and the external memory bus. It owns the tag and data arrays and drives the valid-bit memory (`cache_vmem`), decides hit or miss, refills whole lines word by word on read misses, forwards all stores to memory, and sequences cache flushes.

## Interface
- `INDEX_WIDTH`, default 8. Line index bits; the cache has 2^INDEX_WIDTH lines.
- `OFFSET_WIDTH`, default 3. Word-in-line bits; each line holds 2^OFFSET_WIDTH 32-bit words.
- `TAG_WIDTH`, default 32-2-INDEX_WIDTH-OFFSET_WIDTH (19). Tag bits.
- `clk  in  1` Clock.
- `rst  in  1` Reset, synchronous, active-high.
- `cpu_req  in  1` Request strobe. Sampled only in IDLE.
- `cpu_we  in  1` 1 selects a store, 0 selects a load.
- `cpu_addr  in  32` Byte address. Bits [1:0] are ignored.
- `cpu_wdata  in  32` Store data.
- `cpu_rdata  out  32` Load data. Valid while `cpu_ready` is high; holds its value afterwards.
- `cpu_ready  out  1` One-cycle completion pulse.
- `mem_req  out  1` Memory request. Held high until `mem_ack`.
- `mem_we  out  1` Memory write.
- `mem_addr  out  32` Word-aligned memory address.
- `mem_wdata  out  32` Memory write data.
- `mem_rdata  in  32` Memory read data. Valid when `mem_ack` is high.
- `mem_ack  in  1` One-cycle acknowledge. Ignored while `mem_req` is 0.
- `flush  in  1` Level request to invalidate all lines.
- `flush_busy  out  1` High while in the FLUSH state.

## Operation
- **Address split:** tag = [31:32-TAG_WIDTH]; index = next INDEX_WIDTH bits; offset = next OFFSET_WIDTH bits; [1:0] is dropped.
- **States:** IDLE, LOOKUP, REFILL, WRITE_THRU, FLUSH.
- **IDLE:**
  - `flush` has priority and moves to FLUSH.
  - Otherwise, `cpu_req` latches `cpu_we`, `cpu_addr` and `cpu_wdata`, then moves to LOOKUP.
- **LOOKUP:** hit = valid[index] & (tag_ram[index] == tag). Valid, tag and data reads are asynchronous.
  - Load hit: register `cpu_rdata` = data[index][offset], pulse `cpu_ready`, go to IDLE.
  - Load miss: write valid[index] = 0, clear the word counter, go to REFILL.
  - Store hit: write data[index][offset] = wdata, go to WRITE_THRU.
  - Store miss: go to WRITE_THRU without touching the arrays.
- **REFILL:**
  - Drive `mem_req` = 1, `mem_we` = 0, `mem_addr` = {tag, index, cnt, 2'b00}.
  - On each `mem_ack`, write data[index][cnt] = `mem_rdata` and increment cnt.
  - On the ack with cnt = 2^OFFSET_WIDTH−1: write the tag, write valid = 1, return to LOOKUP. The second lookup then hits.
- **WRITE_THRU:** drive `mem_req` = 1, `mem_we` = 1, `mem_addr` = latched addr with [1:0] = 0, `mem_wdata` = latched wdata. On `mem_ack`, pulse `cpu_ready` and go to IDLE.
- **FLUSH:** lasts one cycle. `cache_vmem` rst = `rst` | (state == FLUSH), so every valid bit clears at the closing edge. Tag and data arrays are never cleared. Return to IDLE.
- **Flush while busy:** `flush` raised during a transaction is acted on at the next IDLE. A level still high after FLUSH triggers another FLUSH.
- **Reset values:** state IDLE, cnt 0, all outputs 0, all valid bits 0.
- **Reset mid-operation:** any outstanding memory transaction is abandoned. The memory side must accept `mem_req` dropping before `mem_ack`.

## Timing
- Load hit: `cpu_req` sampled at edge k; `cpu_ready` is high during cycle k+2 (from edge k+1 to edge k+2). Latency 2.
- Load miss, with memory acking every cycle: LOOKUP, 2^OFFSET_WIDTH REFILL cycles, LOOKUP, then `cpu_ready`. Latency 3 + 2^OFFSET_WIDTH = 11 by default.
- Store: 2 + the number of ack-wait cycles. The minimum is 3.
- The cycle in which `cpu_ready` is high is an IDLE cycle. A `cpu_req` still high at the end of that cycle is accepted as a new request, so back-to-back requests are legal. The requester drops `cpu_req` in the `cpu_ready` cycle unless it is issuing a new request.
- Flush: `flush_busy` is high for exactly 1 cycle per flush. The first post-flush lookup misses.
- The arrays write at the same edge that changes state. A lookup in the following cycle sees the new contents.

## Structure
- The shared package `cache_pkg` holds:
  - the state encoding constants (IDLE = 0 … FLUSH = 4);
  - the default widths;
  - `LINE_WORDS` = 1 << OFFSET_WIDTH.
- Valid bits use the existing `cache_vmem` with DATA_WIDTH = 1 and ADDR_WIDTH = INDEX_WIDTH.
- Tag and data arrays form one natural sub-module, `cache_line_ram`:
  - asynchronous read;
  - synchronous write port for the tag;
  - synchronous write port for one word of data.

## Test plan
- After reset, load 0x0000_0040; memory returns 0x100 + word index. Expect 8 `mem_req` at 0x40..0x5C, then `cpu_ready` with `cpu_rdata` = 0x100. A repeat load to 0x44 returns 0x101 two cycles after the request, with no `mem_req`.
- Store 0xDEAD_BEEF to 0x48 after the refill above. Expect one write at 0x48 with `mem_we` = 1; a following load of 0x48 hits and returns 0xDEAD_BEEF.
- Store to uncached 0x1000. Expect a memory write and `cpu_ready`; a following load of 0x1000 misses and refills.
- Fill a line, assert `flush` for 1 cycle. Expect `flush_busy` high for 1 cycle; reloading the same address misses.
- Assert `rst` midway through a refill (after 3 acks). Expect all outputs 0 next cycle; the next load of that line misses and issues a full 8-word refill.
- Throttle memory: `mem_ack` every 3rd cycle, with `flush` raised during the refill. Expect the refill to complete and return the correct data, FLUSH only afterwards, and `mem_addr` stable while waiting.
